// File: rtl/hs_pipe_reg.sv
// Two-entry skid buffer for a valid/ready stream. Every output is decoded
// from registers, so no input reaches an output through logic alone.
module hs_pipe_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [1:0]            cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  push;
  logic                  pop;

  assign valid_o = (state_q != EMPTY);
  assign ready_o = (state_q != FULL);
  assign cnt_o   = state_q;
  assign dat_o   = main_q;

  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  // A pop in a flush cycle is a completed transfer; a push there is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_q  <= dat_i;
            state_q <= HALF;
          end
        end
        HALF: begin
          if (push && pop) begin
            main_q <= dat_i;
          end else if (push) begin
            skid_q  <= dat_i;
            state_q <= FULL;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_q  <= skid_q;
            state_q <= HALF;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

endmodule
